// File: rtl/sb_pkg.sv
// Shared constants for the decode-stage register scoreboard: latency field
// width, the standard producer latencies and the hardwired-zero register.
package sb_pkg;

  localparam int LAT_W = 3;

  typedef logic [LAT_W-1:0] lat_t;

  localparam lat_t LAT_ALU  = lat_t'(0);
  localparam lat_t LAT_LOAD = lat_t'(1);
  localparam lat_t LAT_MUL  = lat_t'(2);

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard countdown: cycles remaining until the pending result of
// this register reaches a forwarding path. Priority: clear, hold, load, dec.
module sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             hold,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             busy
);

  logic [LAT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every entry
  // samples the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (!hold) begin
      if (load) begin
        cnt <= load_val;
      end else if (dec && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/id_scoreboard.sv
// Per-register latency scoreboard beside decode: raises stallreq while any
// read source still has an outstanding multi-cycle producer.
module id_scoreboard
  import sb_pkg::ZERO_REG;
#(
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5,
  parameter int LAT_W     = sb_pkg::LAT_W,
  parameter int NUM_SRC   = 2,
  parameter int CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_read,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic [ADDR_W-1:0]         issue_dst,
  input  logic [LAT_W-1:0]          issue_lat,
  output logic                      stallreq,
  output logic [REG_COUNT-1:0]      busy_vec,
  output logic [CNT_W-1:0]          stall_cycles
);

  logic [NUM_SRC-1:0]     hazard;
  logic [REG_COUNT-1:ZERO_REG+1] load;
  logic                   issue_fire;

  // Sources only match entries 1..REG_COUNT-1, so register 0 and addresses
  // beyond the register file can never raise a hazard.
  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int r = ZERO_REG + 1; r < REG_COUNT; r++) begin
        if (src_read[i] && src_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r) && busy_vec[r]) begin
          hazard[i] = 1'b1;
        end
      end
    end
  end

  assign stallreq   = issue_valid & (|hazard);
  assign issue_fire = issue_valid & ~stallreq & ~hold & ~flush & ~rst;

  always_comb begin
    load = '0;
    for (int r = ZERO_REG + 1; r < REG_COUNT; r++) begin
      load[r] = issue_fire & issue_we & (issue_dst == ADDR_W'(r));
    end
  end

  assign busy_vec[ZERO_REG] = 1'b0;

  for (genvar r = ZERO_REG + 1; r < REG_COUNT; r++) begin : g_entry
    sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk      (clk),
      .clear    (rst | flush),
      .hold     (hold),
      .load     (load[r]),
      .load_val (issue_lat),
      .dec      (1'b1),
      .busy     (busy_vec[r])
    );
  end

  // Stall statistics survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stallreq && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: a table of per-cycle vectors plus
// hand-written saturation and mid-countdown reset sequences.
module tb_id_scoreboard;

  localparam int REG_COUNT = 24;
  localparam int ADDR_W    = 5;
  localparam int LAT_W     = 3;
  localparam int NUM_SRC   = 2;
  localparam int CNT_W     = 4;

  logic                      clk;
  logic                      rst;
  logic                      hold;
  logic                      flush;
  logic [NUM_SRC-1:0]        src_read;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic                      issue_valid;
  logic                      issue_we;
  logic [ADDR_W-1:0]         issue_dst;
  logic [LAT_W-1:0]          issue_lat;
  logic                      stallreq;
  logic [REG_COUNT-1:0]      busy_vec;
  logic [CNT_W-1:0]          stall_cycles;

  int checks = 0;
  int errors = 0;

  id_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .ADDR_W    (ADDR_W),
    .LAT_W     (LAT_W),
    .NUM_SRC   (NUM_SRC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .flush        (flush),
    .src_read     (src_read),
    .src_addr     (src_addr),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_dst    (issue_dst),
    .issue_lat    (issue_lat),
    .stallreq     (stallreq),
    .busy_vec     (busy_vec),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string                name;
    logic                 rst;
    logic                 hold;
    logic                 flush;
    logic [1:0]           rd;
    logic [ADDR_W-1:0]    a0;
    logic [ADDR_W-1:0]    a1;
    logic                 v;
    logic                 we;
    logic [ADDR_W-1:0]    dst;
    logic [LAT_W-1:0]     lat;
    logic                 e_stall;
    logic [REG_COUNT-1:0] e_busy;
    logic [CNT_W-1:0]     e_sc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic h, logic f,
                              logic [1:0] rd, int a0, int a1,
                              logic v, logic we, int dst, int lat,
                              logic es, logic [REG_COUNT-1:0] eb, int esc);
    vec_t t;
    t.name = name; t.rst = r; t.hold = h; t.flush = f;
    t.rd = rd; t.a0 = ADDR_W'(a0); t.a1 = ADDR_W'(a1);
    t.v = v; t.we = we; t.dst = ADDR_W'(dst); t.lat = LAT_W'(lat);
    t.e_stall = es; t.e_busy = eb; t.e_sc = CNT_W'(esc);
    return t;
  endfunction

  function automatic logic [REG_COUNT-1:0] bit_of(int r);
    logic [REG_COUNT-1:0] b;
    b = '0;
    b[r] = 1'b1;
    return b;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    rst         = t.rst;
    hold        = t.hold;
    flush       = t.flush;
    src_read    = t.rd;
    src_addr    = {t.a1, t.a0};
    issue_valid = t.v;
    issue_we    = t.we;
    issue_dst   = t.dst;
    issue_lat   = t.lat;
  endtask

  task automatic set_inputs(logic r, logic h, logic f, logic [1:0] rd,
                            int a0, int a1, logic v, logic we, int dst, int lat);
    rst = r; hold = h; flush = f; src_read = rd;
    src_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    issue_valid = v; issue_we = we;
    issue_dst = ADDR_W'(dst); issue_lat = LAT_W'(lat);
  endtask

  initial begin
    logic [CNT_W-1:0] exp_sc;

    // Load-use, L=1
    vecs.push_back(mk("a1_issue_r5",  0,0,0, 2'b00, 0,0,  1,1,5,1,  0, '0, 0));
    vecs.push_back(mk("a2_use_r5",    0,0,0, 2'b01, 5,0,  1,0,0,0,  1, bit_of(5), 0));
    vecs.push_back(mk("a3_proceed",   0,0,0, 2'b01, 5,0,  1,0,0,0,  0, '0, 1));
    vecs.push_back(mk("a4_idle",      0,0,0, 2'b00, 0,0,  0,0,0,0,  0, '0, 1));
    // Register 0 never tracked
    vecs.push_back(mk("b0_rst",       1,0,0, 2'b00, 0,0,  0,0,0,0,  0, '0, 1));
    vecs.push_back(mk("b1_issue_r0",  0,0,0, 2'b00, 0,0,  1,1,0,3,  0, '0, 0));
    vecs.push_back(mk("b2_read_r0",   0,0,0, 2'b11, 0,0,  1,0,0,0,  0, '0, 0));
    vecs.push_back(mk("b3_read_r0",   0,0,0, 2'b11, 0,0,  1,0,0,0,  0, '0, 0));
    // Hold extends the busy window
    vecs.push_back(mk("c0_rst",       1,0,0, 2'b00, 0,0,  0,0,0,0,  0, '0, 0));
    vecs.push_back(mk("c1_issue_r7",  0,0,0, 2'b00, 0,0,  1,1,7,3,  0, '0, 0));
    vecs.push_back(mk("c2_hold",      0,1,0, 2'b10, 0,7,  1,0,0,0,  1, bit_of(7), 0));
    vecs.push_back(mk("c3_hold",      0,1,0, 2'b10, 0,7,  1,0,0,0,  1, bit_of(7), 1));
    vecs.push_back(mk("c4_wait",      0,0,0, 2'b10, 0,7,  1,0,0,0,  1, bit_of(7), 2));
    vecs.push_back(mk("c5_wait",      0,0,0, 2'b10, 0,7,  1,0,0,0,  1, bit_of(7), 3));
    vecs.push_back(mk("c6_wait",      0,0,0, 2'b10, 0,7,  1,0,0,0,  1, bit_of(7), 4));
    vecs.push_back(mk("c7_proceed",   0,0,0, 2'b10, 0,7,  1,0,0,0,  0, '0, 5));
    // WAW: newer producer overrides
    vecs.push_back(mk("d0_rst",       1,0,0, 2'b00, 0,0,  0,0,0,0,  0, '0, 5));
    vecs.push_back(mk("d1_issue_r9",  0,0,0, 2'b00, 0,0,  1,1,9,5,  0, '0, 0));
    vecs.push_back(mk("d2_reissue",   0,0,0, 2'b00, 0,0,  1,1,9,1,  0, bit_of(9), 0));
    vecs.push_back(mk("d3_idle",      0,0,0, 2'b00, 0,0,  0,0,0,0,  0, bit_of(9), 0));
    vecs.push_back(mk("d4_idle",      0,0,0, 2'b00, 0,0,  0,0,0,0,  0, '0, 0));
    // Flush discards tracking, keeps statistics
    vecs.push_back(mk("e0_rst",       1,0,0, 2'b00, 0,0,  0,0,0,0,  0, '0, 0));
    vecs.push_back(mk("e1_issue_r3",  0,0,0, 2'b00, 0,0,  1,1,3,7,  0, '0, 0));
    vecs.push_back(mk("e2_use_r3",    0,0,0, 2'b01, 3,0,  1,0,0,0,  1, bit_of(3), 0));
    vecs.push_back(mk("e3_flush",     0,0,1, 2'b00, 0,0,  1,1,4,2,  0, bit_of(3), 1));
    vecs.push_back(mk("e4_after",     0,0,0, 2'b11, 3,4,  1,0,0,0,  0, '0, 1));
    vecs.push_back(mk("e5_idle",      0,0,0, 2'b00, 0,0,  0,0,0,0,  0, '0, 1));
    // Out-of-range addresses and the top register
    vecs.push_back(mk("f0_rst",       1,0,0, 2'b00, 0,0,  0,0,0,0,  0, '0, 1));
    vecs.push_back(mk("f1_issue_r25", 0,0,0, 2'b00, 0,0,  1,1,25,3, 0, '0, 0));
    vecs.push_back(mk("f2_issue_r23", 0,0,0, 2'b01, 25,0, 1,1,23,2, 0, '0, 0));
    vecs.push_back(mk("f3_noread",    0,0,0, 2'b00, 0,23, 1,0,0,0,  0, bit_of(23), 0));
    vecs.push_back(mk("f4_use_r23",   0,0,0, 2'b11, 25,23,1,0,0,0,  1, bit_of(23), 0));
    vecs.push_back(mk("f5_proceed",   0,0,0, 2'b11, 25,23,1,0,0,0,  0, '0, 1));

    // Power-up reset
    set_inputs(1, 0,0, 2'b00, 0,0, 0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    set_inputs(0, 0,0, 2'b01, 5,0, 1,0,0,0);
    @(negedge clk);
    check("reset_stallreq", 32'(stallreq), 32'(1'b0));
    check("reset_busy_vec", 32'(busy_vec), 32'(0));
    check("reset_stall_cycles", 32'(stall_cycles), 32'(0));
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      drive(vecs[k]);
      @(negedge clk);
      check({vecs[k].name, "_stallreq"}, 32'(stallreq), 32'(vecs[k].e_stall));
      check({vecs[k].name, "_busy_vec"}, 32'(busy_vec), 32'(vecs[k].e_busy));
      check({vecs[k].name, "_stall_cycles"}, 32'(stall_cycles), 32'(vecs[k].e_sc));
      @(posedge clk);
      #1;
    end

    // Saturation: producer r1 L=7 frozen by hold while a consumer stalls
    set_inputs(1, 0,0, 2'b00, 0,0, 0,0,0,0);
    @(posedge clk); #1;
    set_inputs(0, 0,0, 2'b00, 0,0, 1,1,1,7);
    @(posedge clk); #1;
    set_inputs(0, 1,0, 2'b01, 1,0, 1,0,0,0);
    exp_sc = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("sat_stallreq", 32'(stallreq), 32'(1'b1));
      check("sat_stall_cycles", 32'(stall_cycles), 32'(exp_sc));
      @(posedge clk); #1;
      if (exp_sc != 4'hF) exp_sc = exp_sc + 4'd1;
    end
    @(negedge clk);
    check("sat_final", 32'(stall_cycles), 32'(4'hF));
    check("sat_busy_vec", 32'(busy_vec), 32'(bit_of(1)));

    // Reset in the middle of a countdown
    @(posedge clk); #1;
    set_inputs(1, 0,0, 2'b01, 1,0, 1,0,0,0);
    @(posedge clk); #1;
    set_inputs(0, 0,0, 2'b01, 1,0, 1,0,0,0);
    @(negedge clk);
    check("midrst_stallreq", 32'(stallreq), 32'(1'b0));
    check("midrst_busy_vec", 32'(busy_vec), 32'(0));
    check("midrst_stall_cycles", 32'(stall_cycles), 32'(0));
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised register scoreboard for the decode stage. It generalises fixed EX/MEM forwarding into per-register latency tracking, so the decode stage can raise a real stall request on load-use and other multi-cycle producer hazards instead of never stalling. It sits beside the decode logic:

- Decode presents the source registers of the instruction currently in ID, plus the destination and result latency of the instruction being issued to EX.
- The scoreboard answers with `stallreq` to the pipeline controller.

## Interface
Parameters:
- `REG_COUNT`, 32, number of architectural registers; register 0 is hardwired zero.
- `ADDR_W`, 5, register address width; `2**ADDR_W >= REG_COUNT`.
- `LAT_W`, 3, latency field width; maximum tracked latency is `2**LAT_W-1`.
- `NUM_SRC`, 2, source operand ports per instruction.
- `CNT_W`, 32, width of the stall statistics counter.

Ports:
- `clk`, in, 1, clock.
- `rst`, in, 1, reset; synchronous, active-high.
- `hold`, in, 1, pipeline frozen this cycle (controller stall from a later stage).
- `flush`, in, 1, pipeline flush; discards all tracking.
- `src_read`, in, `NUM_SRC`, per-port operand read enable.
- `src_addr`, in, `NUM_SRC*ADDR_W`, packed source addresses; port i at bits `[i*ADDR_W +: ADDR_W]`.
- `issue_valid`, in, 1, ID holds a valid instruction requesting issue.
- `issue_we`, in, 1, that instruction writes a register.
- `issue_dst`, in, `ADDR_W`, its destination address.
- `issue_lat`, in, `LAT_W`, cycles after issue before its result is on a forwarding path. 0 means ALU-type, forwardable immediately from EX.
- `stallreq`, out, 1, ID must not issue this cycle.
- `busy_vec`, out, `REG_COUNT`, bit r set when register r has a nonzero countdown.
- `stall_cycles`, out, `CNT_W`, saturating count of cycles with `stallreq=1`.

## Operation
- Each register r has a countdown `cnt[r]` of `LAT_W` bits. Register 0 is constant 0.
- Hazard:
  - Port i is hazardous when `src_read[i]`, `src_addr_i != 0`, and `cnt[src_addr_i] != 0`.
  - `stallreq` = OR over ports of hazardous AND `issue_valid`.
  - `stallreq` is combinational and evaluated against current counters, so an instruction reading its own destination checks only the older producer.
- Issue fires when `issue_valid & ~stallreq & ~hold & ~flush & ~rst`.
- Per-cycle update of each register r, first matching rule wins:
  1. `rst` or `flush`: all `cnt` cleared to 0.
  2. `hold`: counters unchanged.
  3. Issue fires with `issue_we`, `issue_dst == r`, `r != 0`: `cnt[r] <= issue_lat`. This overrides the decrement and replaces any older pending value (WAW: the newer producer wins).
  4. `cnt[r] != 0`: `cnt[r] <= cnt[r]-1`.
  5. Otherwise unchanged.
- Addresses at or above `REG_COUNT` are ignored:
  - as a destination, no counter changes;
  - as a source, the port is never hazardous.
- `stall_cycles`:
  - increments each cycle `stallreq=1` and `rst=0`;
  - saturates at all-ones;
  - is not cleared by `flush`.
- `busy_vec[r] = (cnt[r] != 0)`; bit 0 is always 0.

## Timing
- Reset values: all `cnt` = 0, `busy_vec` = 0, `stall_cycles` = 0, `stallreq` = 0.
- Producer issued in cycle t with latency L, all non-hold cycles:
  - a consumer reading the same register in cycles t+1 .. t+L sees `stallreq=1`;
  - from cycle t+L+1 it proceeds.
  - L=0 never stalls; L=1 gives exactly one load-use bubble.
- Each `hold` cycle extends the busy window by one cycle.
- `flush` in cycle t: no stall from any earlier producer in cycle t+1. The instruction presented during flush is not recorded.
- `rst` mid-countdown: all state cleared next cycle, identical to power-up.
- Zero-cycle latency from `src_*` to `stallreq`; one cycle from issue to `busy_vec`.

## Structure
- Shared package `sb_pkg`:
  - `LAT_W`;
  - latency constants `LAT_ALU=0`, `LAT_LOAD=1`, `LAT_MUL=2`;
  - the zero-register address constant.
- Sub-module `sb_entry`: one countdown register with load / decrement / hold / clear inputs and a busy output, instantiated in a generate loop for r = 1 .. `REG_COUNT-1`.
- The top level holds the source-port hazard OR tree, the issue decode and the statistics counter.

## Test plan
- Issue r5 with L=1, next cycle read r5 on port 0 -> `stallreq=1` for exactly one cycle, then 0; `busy_vec[5]` high for one cycle.
- Issue r0 with L=3, then read r0 -> `stallreq=0` throughout; `busy_vec=0`.
- Issue r7 with L=3, assert `hold` for 2 cycles, read r7 on port 1 -> `stallreq=1` for 5 cycles total, `stall_cycles=5`.
- Issue r9 with L=5, next cycle issue r9 with L=1 (no r9 reads) -> `cnt[9]=1`, `busy_vec[9]` clears after 1 cycle (WAW overwrite).
- Issue r3 with L=7, assert `flush` in the following cycle -> `busy_vec=0` next cycle; a read of r3 gives `stallreq=0`; `stall_cycles` unchanged.
- Set `stall_cycles` near saturation (`CNT_W=4`), stall 20 cycles -> holds at 15.
